// File: rtl/pine_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pine_cpu_pkg
// Description : Shared operand-fetch state encoding and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package pine_cpu_pkg;

    localparam int unsigned c_ADDR_W = 4;
    localparam int unsigned c_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ISS1 = 3'd1,
        ST_ISS2 = 3'd2,
        ST_CAP1 = 3'd3,
        ST_CAP2 = 3'd4,
        ST_OUT  = 3'd5
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/opnd_slot.sv
`default_nettype none
// ============================================================================
// Module      : opnd_slot
// Description : One operand: address latch, issue-cycle forward, capture mux
//               and writeback snoop of the held value.
// Revision    : 1.0 - initial release
// ============================================================================
module opnd_slot
    import pine_cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = c_ADDR_W,
    parameter int unsigned DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic              issue_i,
    input  logic              capture_i,
    input  logic              clear_i,
    input  logic              hold_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [DATA_W-1:0] wb_din_i,
    input  logic [DATA_W-1:0] rf_dout_i,
    output logic [ADDR_W-1:0] adr_o,
    output logic [DATA_W-1:0] data_o
);

    logic [ADDR_W-1:0] adr_q,   adr_d;
    logic              fwd_q,   fwd_d;
    logic [DATA_W-1:0] fdata_q, fdata_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              w_hit;

    assign w_hit  = wb_we_i && (wb_adr_i == adr_q);
    assign adr_o  = adr_q;
    assign data_o = data_q;

    always_comb begin
        adr_d   = adr_q;
        fwd_d   = fwd_q;
        fdata_d = fdata_q;
        data_d  = data_q;
        if (load_i) begin
            adr_d = adr_i;
            fwd_d = 1'b0;
        end
        // The register file may return the pre-write value for a same-cycle write
        if (issue_i) begin
            fwd_d   = w_hit;
            fdata_d = wb_din_i;
        end
        if (capture_i) begin
            if (w_hit) begin
                data_d = wb_din_i;
            end else if (fwd_q) begin
                data_d = fdata_q;
            end else begin
                data_d = rf_dout_i;
            end
        end else if (clear_i) begin
            data_d = '0;
        end else if (hold_i && w_hit) begin
            data_d = wb_din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            adr_q   <= '0;
            fwd_q   <= 1'b0;
            fdata_q <= '0;
            data_q  <= '0;
        end else begin
            adr_q   <= adr_d;
            fwd_q   <= fwd_d;
            fdata_q <= fdata_d;
            data_q  <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Sequences one or two reads of a single-port register file
//               per decoded instruction and hands fresh operands to execute.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch
    import pine_cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = c_ADDR_W,
    parameter int unsigned DATA_W = c_DATA_W,
    parameter int unsigned TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              in_use_rs2,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [DATA_W-1:0] wb_din,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wadr,
    output logic [DATA_W-1:0] rf_din,
    output logic [ADDR_W-1:0] rf_radr,
    input  logic [DATA_W-1:0] rf_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [TAG_W-1:0]  out_tag
);

    fetch_state_t      state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              use2_q;
    logic [TAG_W-1:0]  tag_q;

    logic              w_accept;
    logic              w_issue1, w_cap1, w_hold1;
    logic              w_issue2, w_cap2, w_clear2, w_hold2;
    logic [ADDR_W-1:0] w_adr1, w_adr2;

    assign w_accept = (state_q == ST_IDLE) && in_valid;
    assign w_issue1 = (state_q == ST_ISS1);
    assign w_cap1   = (state_q == ST_ISS2) || (state_q == ST_CAP1);
    assign w_hold1  = (state_q == ST_CAP2) || (state_q == ST_OUT);
    assign w_issue2 = (state_q == ST_ISS2);
    assign w_cap2   = (state_q == ST_CAP2);
    assign w_clear2 = (state_q == ST_CAP1);
    assign w_hold2  = (state_q == ST_OUT) && use2_q;

    assign rf_we     = wb_we & ~reset;
    assign rf_wadr   = wb_adr;
    assign rf_din    = wb_din;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_tag   = tag_q;

    // Read address is a pure decode of registered state and latched addresses
    always_comb begin
        rf_radr = '0;
        if (state_q == ST_ISS1) begin
            rf_radr = w_adr1;
        end else if (state_q == ST_ISS2) begin
            rf_radr = w_adr2;
        end
    end

    opnd_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
        .clk       (clk),
        .reset     (reset),
        .load_i    (w_accept),
        .adr_i     (in_rs1),
        .issue_i   (w_issue1),
        .capture_i (w_cap1),
        .clear_i   (1'b0),
        .hold_i    (w_hold1),
        .wb_we_i   (wb_we),
        .wb_adr_i  (wb_adr),
        .wb_din_i  (wb_din),
        .rf_dout_i (rf_dout),
        .adr_o     (w_adr1),
        .data_o    (out_op1)
    );

    opnd_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot2 (
        .clk       (clk),
        .reset     (reset),
        .load_i    (w_accept),
        .adr_i     (in_rs2),
        .issue_i   (w_issue2),
        .capture_i (w_cap2),
        .clear_i   (w_clear2),
        .hold_i    (w_hold2),
        .wb_we_i   (wb_we),
        .wb_adr_i  (wb_adr),
        .wb_din_i  (wb_din),
        .rf_dout_i (rf_dout),
        .adr_o     (w_adr2),
        .data_o    (out_op2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            use2_q      <= 1'b0;
            tag_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q    <= ST_ISS1;
                        in_ready_q <= 1'b0;
                        use2_q     <= in_use_rs2;
                        tag_q      <= in_tag;
                    end
                end
                ST_ISS1: state_q <= use2_q ? ST_ISS2 : ST_CAP1;
                ST_ISS2: state_q <= ST_CAP2;
                ST_CAP1, ST_CAP2: begin
                    state_q     <= ST_OUT;
                    out_valid_q <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
